isqrt_shared_arbiter: RTL and testbench
=======================================

Name: isqrt_shared_arbiter

Overview:
Shares one pipelined isqrt unit between N_REQ independent requesters. The isqrt unit is in-order, has a fixed but unknown latency, and has no backpressure.
- Grants issue slots round-robin and drives the isqrt input.
- Records each issue's owner in an in-order tag FIFO.
- Routes each isqrt result back to its owner with a one-hot response valid.
- Sits between formula controllers (the requesters) and the single shared isqrt instance.

Parameters:
N_REQ, 4, number of requesters (2..8).
MAX_INFLIGHT, 16, tag FIFO depth; the maximum number of issued-but-unreturned requests (power of two, at least the isqrt pipeline latency).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_vld  input  N_REQ  per-requester request valid
req_x  input  N_REQ*32  per-requester operand; slice i is bits [32*i+31:32*i]
req_rdy  output  N_REQ  per-requester accept; a transfer happens when req_vld[i] and req_rdy[i] are both high
rsp_vld  output  N_REQ  one-hot result valid, registered
rsp_y  output  16  result, shared by all requesters, registered
isqrt_x_vld  output  1  isqrt input valid
isqrt_x  output  32  isqrt operand
isqrt_y_vld  input  1  isqrt result valid
isqrt_y  input  16  isqrt result
busy  output  1  high when the tag FIFO is not empty
err_unexpected  output  1  sticky flag: a result arrived while the tag FIFO was empty

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - rr_ptr=0, FIFO count/rd/wr pointers = 0.
  - rsp_vld=0, rsp_y=0, err_unexpected=0.
  - Combinational outputs (req_rdy, isqrt_x_vld, isqrt_x, busy) evaluate to 0 while count=0 and no grant.
- Grant (combinational):
  - full = (count == MAX_INFLIGHT), using the registered count.
  - When not full, grant = the first i with req_vld[i]=1, searching from rr_ptr upward with wrap-around.
  - req_rdy = one-hot grant; all zero when full or when no request is pending.
  - req_rdy[i] may depend on req_vld; requesters must not make req_vld depend on req_rdy.
- Issue (same cycle as grant):
  - isqrt_x_vld = |(req_vld & req_rdy); isqrt_x = req_x[granted]; otherwise isqrt_x = 0.
  - On issue: push the granted index into the tag FIFO and set rr_ptr = (granted+1) mod N_REQ.
  - With no issue, rr_ptr holds.
- Return:
  - On isqrt_y_vld with count>0: pop tag t.
  - Next cycle: rsp_vld = one-hot(t), rsp_y = isqrt_y.
  - Cycles with no pop: rsp_vld = 0 and rsp_y holds its last value.
  - Latency from accept to rsp_vld = isqrt latency + 1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, a same-cycle pop does NOT enable a push; the grant uses registered full.
- isqrt_y_vld with count=0: set err_unexpected (held until reset), no pop, rsp_vld stays 0.
- Pointers wrap modulo MAX_INFLIGHT. count is $clog2(MAX_INFLIGHT)+1 bits wide.
- Reset mid-operation: the FIFO is discarded. Results already in the isqrt pipe that arrive after reset set err_unexpected.
  - Integration must reset the isqrt unit together with this block.
- busy = (count != 0).

Decomposition:
- Shared package isqrt_arb_pkg holds:
  - the default N_REQ and MAX_INFLIGHT;
  - the tag_t width localparam $clog2(N_REQ);
  - function rr_pick(vld, ptr), which returns the granted index and a found bit.
- Natural sub-module: isqrt_tag_fifo, a synchronous FIFO (depth MAX_INFLIGHT, width tag_t) with push/pop/full/empty/count.
- The round-robin pick stays in the top level.

Test Plan:
- Single requester, N_REQ=4, isqrt latency 3:
  - req 1 with x=49 is accepted in cycle 0.
  - isqrt_x_vld=1, isqrt_x=49 in cycle 0.
  - rsp_vld=4'b0010, rsp_y=7 in cycle 4.
- All four requesters hold req_vld continuously with x=i*i+100:
  - grants go 0,1,2,3,0,... one per cycle;
  - responses return in the same order with correct per-owner values;
  - no requester is starved.
- MAX_INFLIGHT=4, isqrt latency 8, constant requests:
  - exactly 4 issues, then req_rdy=0 until the first result;
  - in the pop cycle no push happens; push resumes the next cycle;
  - count never exceeds 4.
- Sparse pattern, req_vld=4'b1010 with rr_ptr=2:
  - grant goes to 3, then 1, then 3;
  - rr_ptr skips idle requesters.
- Spurious isqrt_y_vld=1 with an empty FIFO:
  - err_unexpected=1 from the next cycle and stays high;
  - rsp_vld stays 0;
  - a later normal transaction still completes correctly.
- Assert rst_n=0 with 3 requests in flight:
  - all outputs are 0 immediately, without waiting for a clock;
  - after release, busy=0 and the first grant goes to requester 0.

Source files
------------

// File: rtl/isqrt_shared_arbiter_pkg.sv
// Shared definitions for the isqrt arbiter: defaults, tag type and the
// round-robin pick helper.
package isqrt_arb_pkg;

  localparam int unsigned N_REQ_DEF        = 4;
  localparam int unsigned MAX_INFLIGHT_DEF = 16;
  localparam int unsigned N_REQ_MAX        = 8;
  // Sized for the largest supported requester count so any legal N_REQ fits.
  localparam int unsigned TAG_W            = $clog2(N_REQ_MAX);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic found;
    tag_t idx;
  } pick_t;

  // First asserted vld at or above ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [N_REQ_MAX-1:0] vld,
                                    input tag_t                 ptr,
                                    input int unsigned          n);
    pick_t       p;
    int unsigned j;
    tag_t        jt;
    p = '0;
    for (int unsigned k = 0; k < N_REQ_MAX; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      jt = tag_t'(j);
      if (k < n && !p.found && vld[jt]) begin
        p.found = 1'b1;
        p.idx   = jt;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/isqrt_shared_arbiter_if.sv
// Requester-side bus of the shared isqrt arbiter.
interface isqrt_shared_arbiter_if
  import isqrt_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) ();

  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ*32-1:0] req_x;
  logic [N_REQ-1:0]    req_rdy;
  logic [N_REQ-1:0]    rsp_vld;
  logic [15:0]         rsp_y;

  modport master (output req_vld, req_x, input req_rdy, rsp_vld, rsp_y);
  modport slave  (input req_vld, req_x, output req_rdy, rsp_vld, rsp_y);

endinterface

// File: rtl/isqrt_shared_arbiter_tag_fifo.sv
// In-order owner-tag FIFO; one entry per issued-but-unreturned isqrt operation.
module isqrt_tag_fifo
  import isqrt_arb_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_INFLIGHT_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  tag_t        push_tag,
  input  logic        pop,
  output tag_t        pop_tag,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  tag_t          mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_tag = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/isqrt_shared_arbiter.sv
// Round-robin sharing of one in-order pipelined isqrt unit between N_REQ
// requesters, with in-order owner tracking and one-hot result routing.
module isqrt_shared_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  isqrt_shared_arbiter_if.slave  req_bus,
  output logic                   isqrt_x_vld,
  output logic [31:0]            isqrt_x,
  input  logic                   isqrt_y_vld,
  input  logic [15:0]            isqrt_y,
  output logic                   busy,
  output logic                   err_unexpected
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT) + 1;

  tag_t                 rr_ptr;
  pick_t                pick;
  logic [N_REQ_MAX-1:0] vld_ext;
  logic                 grant;
  logic [N_REQ-1:0]     gnt_oh;
  logic [31:0]          x_mux;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  tag_t                 pop_tag;
  logic                 pop;
  logic [N_REQ-1:0]     rsp_oh;
  logic [N_REQ-1:0]     rsp_vld_q;
  logic [15:0]          rsp_y_q;

  // Grant uses the registered full flag, so a same-cycle pop never frees a slot.
  always_comb begin
    vld_ext              = '0;
    vld_ext[N_REQ-1:0]   = req_bus.req_vld;
    pick                 = rr_pick(vld_ext, rr_ptr, N_REQ);
    grant                = pick.found && !fifo_full;
    gnt_oh               = '0;
    x_mux                = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant && pick.idx == tag_t'(i)) begin
        gnt_oh[i] = 1'b1;
        x_mux     = req_bus.req_x[32*i +: 32];
      end
    end
  end

  always_comb begin
    rsp_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pop_tag == tag_t'(i)) rsp_oh[i] = 1'b1;
    end
  end

  assign req_bus.req_rdy = gnt_oh;
  assign isqrt_x_vld     = |(req_bus.req_vld & gnt_oh);
  assign isqrt_x         = x_mux;
  assign pop             = isqrt_y_vld && !fifo_empty;
  assign busy            = (fifo_count != '0);
  assign req_bus.rsp_vld = rsp_vld_q;
  assign req_bus.rsp_y   = rsp_y_q;

  isqrt_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (isqrt_x_vld),
    .push_tag (pick.idx),
    .pop      (pop),
    .pop_tag  (pop_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      rsp_vld_q      <= '0;
      rsp_y_q        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (isqrt_x_vld) begin
        rr_ptr <= (pick.idx == tag_t'(N_REQ-1)) ? '0 : tag_t'(pick.idx + 1'b1);
      end
      rsp_vld_q <= pop ? rsp_oh : '0;
      if (pop) rsp_y_q <= isqrt_y;
      if (isqrt_y_vld && fifo_empty) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_isqrt_shared_arbiter.sv
// Bench for isqrt_shared_arbiter: two instances (deep and shallow tag FIFO),
// each fed by a behavioural isqrt pipe with programmable latency.
module tb_isqrt_shared_arbiter;
  import isqrt_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  isqrt_shared_arbiter_if #(.N_REQ(4)) bus_a ();
  isqrt_shared_arbiter_if #(.N_REQ(4)) bus_b ();

  logic        a_xv, b_xv, a_busy, b_busy, a_err, b_err;
  logic [31:0] a_x, b_x;

  logic [3:0]  tb_vld [2];
  logic [31:0] tb_x   [2][4];
  logic        inj    [2];
  int          lat    [2];
  logic        pipe_rst;
  logic        pv [2][32];
  logic [31:0] px [2][32];

  logic [3:0]  o_rdy [2];
  logic [3:0]  o_rv  [2];
  logic [15:0] o_ry  [2];
  logic        o_xv  [2];
  logic [31:0] o_x   [2];
  logic        o_busy[2];
  logic        o_err [2];
  logic        yv    [2];
  logic [15:0] yo    [2];

  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    logic [15:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = {16'b0, r | 16'(1 << b)};
      if (t * t <= x) r = r | 16'(1 << b);
    end
    return r;
  endfunction

  assign bus_a.req_vld = tb_vld[0];
  assign bus_b.req_vld = tb_vld[1];
  assign bus_a.req_x   = {tb_x[0][3], tb_x[0][2], tb_x[0][1], tb_x[0][0]};
  assign bus_b.req_x   = {tb_x[1][3], tb_x[1][2], tb_x[1][1], tb_x[1][0]};
  assign o_rdy[0] = bus_a.req_rdy;  assign o_rdy[1] = bus_b.req_rdy;
  assign o_rv[0]  = bus_a.rsp_vld;  assign o_rv[1]  = bus_b.rsp_vld;
  assign o_ry[0]  = bus_a.rsp_y;    assign o_ry[1]  = bus_b.rsp_y;
  assign o_xv[0]  = a_xv;           assign o_xv[1]  = b_xv;
  assign o_x[0]   = a_x;            assign o_x[1]   = b_x;
  assign o_busy[0] = a_busy;        assign o_busy[1] = b_busy;
  assign o_err[0] = a_err;          assign o_err[1] = b_err;
  assign yv[0] = pv[0][lat[0]-1] | inj[0];
  assign yv[1] = pv[1][lat[1]-1] | inj[1];
  assign yo[0] = isqrt_ref(px[0][lat[0]-1]);
  assign yo[1] = isqrt_ref(px[1][lat[1]-1]);

  isqrt_shared_arbiter #(.N_REQ(4), .MAX_INFLIGHT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_bus(bus_a),
    .isqrt_x_vld(a_xv), .isqrt_x(a_x), .isqrt_y_vld(yv[0]), .isqrt_y(yo[0]),
    .busy(a_busy), .err_unexpected(a_err));

  isqrt_shared_arbiter #(.N_REQ(4), .MAX_INFLIGHT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_bus(bus_b),
    .isqrt_x_vld(b_xv), .isqrt_x(b_x), .isqrt_y_vld(yv[1]), .isqrt_y(yo[1]),
    .busy(b_busy), .err_unexpected(b_err));

  // Environment: fixed-latency, in-order isqrt with no backpressure.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pipe_rst) begin
        for (int k = 0; k < 32; k++) begin
          pv[d][k] <= 1'b0;
          px[d][k] <= '0;
        end
      end else begin
        pv[d][0] <= o_xv[d];
        px[d][0] <= o_x[d];
        for (int k = 1; k < 32; k++) begin
          pv[d][k] <= pv[d][k-1];
          px[d][k] <= px[d][k-1];
        end
      end
    end
  end

  // Reference model state: owner/operand queue in issue order.
  int          n_chk = 0;
  int          n_fail = 0;
  int          mi [2] = '{16, 4};
  int          mptr [2], mcount [2], head [2], tail [2];
  int          own [2][64];
  logic [31:0] mx [2][64];
  logic [3:0]  exp_rv [2];
  logic [15:0] exp_ry [2];
  logic        merr [2];
  logic [3:0]  cap_rdy [2], cap_rv [2];
  logic [15:0] cap_ry [2];
  logic [31:0] cap_x [2];
  logic        cap_xv [2], cap_busy [2], cap_err [2];
  int          cnt_g [2][4], cnt_r [2][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mptr[d] = 0; mcount[d] = 0; head[d] = 0; tail[d] = 0;
      exp_rv[d] = '0; exp_ry[d] = '0; merr[d] = 1'b0;
    end
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        cnt_g[d][i] = 0; cnt_r[d][i] = 0;
      end
  endtask

  task automatic check_dut(input int d);
    logic [3:0]  v;
    logic [3:0]  erdy;
    logic [31:0] ex;
    int          g;
    v = tb_vld[d];
    g = -1;
    if (mcount[d] < mi[d]) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (mptr[d] + k) % 4;
        if (g < 0 && v[j]) g = j;
      end
    end
    erdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    ex   = (g >= 0) ? tb_x[d][g] : 32'b0;
    chk($sformatf("req_rdy[%0d]", d), 32'(o_rdy[d]), 32'(erdy));
    chk($sformatf("isqrt_x_vld[%0d]", d), 32'(o_xv[d]), 32'(g >= 0));
    chk($sformatf("isqrt_x[%0d]", d), o_x[d], ex);
    chk($sformatf("busy[%0d]", d), 32'(o_busy[d]), 32'(mcount[d] != 0));
    chk($sformatf("rsp_vld[%0d]", d), 32'(o_rv[d]), 32'(exp_rv[d]));
    chk($sformatf("rsp_y[%0d]", d), 32'(o_ry[d]), 32'(exp_ry[d]));
    chk($sformatf("err_unexpected[%0d]", d), 32'(o_err[d]), 32'(merr[d]));
    cap_rdy[d] = o_rdy[d]; cap_rv[d] = o_rv[d]; cap_ry[d] = o_ry[d];
    cap_x[d] = o_x[d]; cap_xv[d] = o_xv[d];
    cap_busy[d] = o_busy[d]; cap_err[d] = o_err[d];
    for (int i = 0; i < 4; i++) begin
      cnt_g[d][i] += int'(o_rdy[d][i]);
      cnt_r[d][i] += int'(o_rv[d][i]);
    end
    exp_rv[d] = '0;
    if (yv[d]) begin
      if (mcount[d] > 0) begin
        exp_rv[d] = 4'(1 << own[d][head[d]]);
        exp_ry[d] = isqrt_ref(mx[d][head[d]]);
        head[d]   = (head[d] + 1) % 64;
        mcount[d] = mcount[d] - 1;
      end else begin
        merr[d] = 1'b1;
      end
    end
    if (g >= 0) begin
      own[d][tail[d]] = g;
      mx[d][tail[d]]  = ex;
      tail[d]   = (tail[d] + 1) % 64;
      mcount[d] = mcount[d] + 1;
      mptr[d]   = (g + 1) % 4;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tb_vld[0] = '0; tb_vld[1] = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic flush);
    tb_vld[0] = '0; tb_vld[1] = '0; inj[0] = 1'b0; inj[1] = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_rdy", 32'(o_rdy[d]), 32'd0);
      chk("rst_isqrt_x_vld", 32'(o_xv[d]), 32'd0);
      chk("rst_isqrt_x", o_x[d], 32'd0);
      chk("rst_busy", 32'(o_busy[d]), 32'd0);
      chk("rst_rsp_vld", 32'(o_rv[d]), 32'd0);
      chk("rst_rsp_y", 32'(o_ry[d]), 32'd0);
      chk("rst_err", 32'(o_err[d]), 32'd0);
    end
    model_reset();
    if (flush) pipe_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pipe_rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      tb_vld[d] = '0; inj[d] = 1'b0;
      for (int i = 0; i < 4; i++) tb_x[d][i] = '0;
    end
    lat[0] = 3; lat[1] = 8;
    pipe_rst = 1'b1;
    model_reset();
    clear_counts();
    do_reset(1'b1);

    // Single requester, latency 3
    tb_vld[0] = 4'b0010; tb_x[0][1] = 32'd49;
    tick();
    chk("t1_rdy", 32'(cap_rdy[0]), 32'h2);
    chk("t1_x", cap_x[0], 32'd49);
    idle(3);
    chk("t1_rsp_early", 32'(cap_rv[0]), 32'h0);
    tick();
    chk("t1_rsp_vld", 32'(cap_rv[0]), 32'h2);
    chk("t1_rsp_y", 32'(cap_ry[0]), 32'd7);

    // All four requesters continuously
    do_reset(1'b1);
    clear_counts();
    for (int i = 0; i < 4; i++) tb_x[0][i] = 32'(i * i + 100);
    tb_vld[0] = 4'hF;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t2_grant_order", 32'(cap_rdy[0]), 32'(1 << (k % 4)));
    end
    idle(10);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_grants[%0d]", i), 32'(cnt_g[0][i]), 32'd4);
      chk($sformatf("t2_rsps[%0d]", i), 32'(cnt_r[0][i]), 32'd4);
    end

    // Shallow FIFO, latency 8: fill, stall, no push in the pop cycle
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) tb_x[1][i] = 32'(1000 + i * 37);
    tb_vld[1] = 4'hF;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k < 10)
        chk($sformatf("t3_rdy_c%0d", k), 32'(cap_rdy[1]),
            (k < 4) ? 32'(1 << k) : ((k == 9) ? 32'h1 : 32'h0));
    end
    idle(12);

    // Sparse requests with rr_ptr at 2
    do_reset(1'b1);
    tb_x[0][1] = 32'd81; tb_x[0][3] = 32'd1_000_000;
    tb_vld[0] = 4'b0010;
    tick();
    chk("t4_setup", 32'(cap_rdy[0]), 32'h2);
    tb_vld[0] = 4'b1010;
    tick(); chk("t4_g0", 32'(cap_rdy[0]), 32'h8);
    tick(); chk("t4_g1", 32'(cap_rdy[0]), 32'h2);
    tick(); chk("t4_g2", 32'(cap_rdy[0]), 32'h8);
    idle(8);

    // Spurious result with an empty FIFO
    inj[0] = 1'b1;
    tick();
    chk("t5_err_before", 32'(cap_err[0]), 32'h0);
    inj[0] = 1'b0;
    tick();
    chk("t5_err_set", 32'(cap_err[0]), 32'h1);
    chk("t5_no_rsp", 32'(cap_rv[0]), 32'h0);
    tb_vld[0] = 4'b0100; tb_x[0][2] = 32'd144;
    tick();
    idle(3);
    tick();
    chk("t5_rsp_vld", 32'(cap_rv[0]), 32'h4);
    chk("t5_rsp_y", 32'(cap_ry[0]), 32'd12);
    chk("t5_err_held", 32'(cap_err[0]), 32'h1);
    idle(4);

    // Reset with three requests in flight; stale results then flag an error
    lat[0] = 6;
    tb_vld[0] = 4'hF;
    repeat (3) tick();
    do_reset(1'b0);
    tick();
    chk("t6_busy", 32'(cap_busy[0]), 32'h0);
    idle(7);
    chk("t6_stale_err", 32'(cap_err[0]), 32'h1);
    tb_vld[0] = 4'hF;
    tick();
    chk("t6_first_grant", 32'(cap_rdy[0]), 32'h1);
    idle(10);

    // Randomized traffic on both instances
    for (int r = 0; r < 4; r++) begin
      lat[0] = int'($urandom_range(1, 12));
      lat[1] = int'($urandom_range(2, 8));
      for (int c = 0; c < 80; c++) begin
        for (int d = 0; d < 2; d++) begin
          tb_vld[d] = 4'($urandom);
          for (int i = 0; i < 4; i++) tb_x[d][i] = $urandom;
        end
        tick();
      end
      idle(16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
